// File: rtl/lt24_pkg.sv
// Shared constants for the LT24 panel reset sequencer: state encoding,
// register map and default timings.
package lt24_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAssert = 3'd1,
        StWait   = 3'd2,
        StReady  = 3'd3,
        StHold   = 3'd4
    } lt24_state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_LOW    = 2'd2;
    localparam logic [1:0] ADDR_WAIT   = 2'd3;

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_HOLD_BIT   = 1;
    localparam int unsigned STAT_DONE_BIT   = 3;
    localparam int unsigned STAT_IRQ_EN_BIT = 4;

    localparam int unsigned CNT_W_DEFAULT    = 24;
    localparam int unsigned LOW_DEFAULT_CYC  = 500;
    localparam int unsigned WAIT_DEFAULT_CYC = 6000000;

endpackage

// File: rtl/lt24_reset_sequencer_if.sv
// Avalon-MM slave port of the LT24 reset sequencer (zero-latency reads).
interface lt24_reset_sequencer_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/lt24_delay_counter.sv
// Down-counter for sequence phase timing: load has priority, decrement
// saturates at zero, zero flag is combinational from the count.
module lt24_delay_counter #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/lt24_reset_sequencer.sv
// Avalon-MM slave driving the LT24 panel's active-low reset through
// assert-low, release and wake-up wait, then flagging panel-ready.
module lt24_reset_sequencer
    import lt24_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEFAULT,
    parameter int unsigned LOW_DEFAULT  = LOW_DEFAULT_CYC,
    parameter int unsigned WAIT_DEFAULT = WAIT_DEFAULT_CYC,
    parameter int unsigned AUTO_START   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    lt24_reset_sequencer_if.slave bus,
    output logic                  lcd_reset_n,
    output logic                  lcd_ready,
    output logic                  irq
);

    lt24_state_e      state_q, state_d;
    logic             lcd_reset_n_q, lcd_ready_q;
    logic             hold_q, done_q, done_d, irq_en_q, first_q;
    logic [CNT_W-1:0] low_cyc_q, wait_cyc_q;
    logic [CNT_W-1:0] low_load, wait_load;
    logic             cnt_load, cnt_dec, cnt_zero, set_done;
    logic [CNT_W-1:0] cnt_val;
    logic             wr, wr_ctrl, wr_status, wr_low, wr_wait;
    logic             start, hold_req, auto_go;
    logic             unused_wdata;

    assign wr        = bus.chipselect && !bus.write_n;
    assign wr_ctrl   = wr && (bus.address == ADDR_CTRL);
    assign wr_status = wr && (bus.address == ADDR_STATUS);
    assign wr_low    = wr && (bus.address == ADDR_LOW);
    assign wr_wait   = wr && (bus.address == ADDR_WAIT);

    assign start    = wr_ctrl && bus.writedata[CTRL_START_BIT];
    // A HOLD write acts in the same cycle it is written, ahead of START.
    assign hold_req = wr_ctrl ? bus.writedata[CTRL_HOLD_BIT] : hold_q;
    assign auto_go  = (AUTO_START != 0) && first_q;

    // Zero-length phases still last one cycle.
    assign low_load  = (low_cyc_q == '0) ? '0 : low_cyc_q - CNT_W'(1);
    assign wait_load = (wait_cyc_q == '0) ? '0 : wait_cyc_q - CNT_W'(1);

    assign unused_wdata = ^bus.writedata;

    lt24_delay_counter #(
        .CNT_W (CNT_W)
    ) u_delay_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        set_done = 1'b0;
        if (hold_req) begin
            state_d = StHold;
        end else if (start || (state_q == StHold) || ((state_q == StIdle) && auto_go)) begin
            state_d  = StAssert;
            cnt_load = 1'b1;
            cnt_val  = low_load;
        end else begin
            case (state_q)
                StAssert: begin
                    if (cnt_zero) begin
                        state_d  = StWait;
                        cnt_load = 1'b1;
                        cnt_val  = wait_load;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                StWait: begin
                    if (cnt_zero) begin
                        state_d  = StReady;
                        set_done = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            lcd_reset_n_q <= 1'b0;
            lcd_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lcd_reset_n_q <= (state_d == StWait) || (state_d == StReady);
            lcd_ready_q   <= (state_d == StReady);
        end
    end

    // Completion wins over a same-cycle software clear.
    always_comb begin
        done_d = done_q;
        if (set_done) begin
            done_d = 1'b1;
        end else if (wr_status && bus.writedata[STAT_DONE_BIT]) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q    <= 1'b1;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            low_cyc_q  <= CNT_W'(LOW_DEFAULT);
            wait_cyc_q <= CNT_W'(WAIT_DEFAULT);
        end else begin
            first_q <= 1'b0;
            done_q  <= done_d;
            if (wr_ctrl) begin
                hold_q <= bus.writedata[CTRL_HOLD_BIT];
            end
            if (wr_status) begin
                irq_en_q <= bus.writedata[STAT_IRQ_EN_BIT];
            end
            if (wr_low) begin
                low_cyc_q <= bus.writedata[CNT_W-1:0];
            end
            if (wr_wait) begin
                wait_cyc_q <= bus.writedata[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        if (bus.chipselect) begin
            case (bus.address)
                ADDR_CTRL:   bus.readdata = {30'b0, hold_q, 1'b0};
                ADDR_STATUS: bus.readdata = {27'b0, irq_en_q, done_q, state_q};
                ADDR_LOW:    bus.readdata = 32'(low_cyc_q);
                ADDR_WAIT:   bus.readdata = 32'(wait_cyc_q);
                default:     bus.readdata = '0;
            endcase
        end
    end

    assign lcd_reset_n = lcd_reset_n_q;
    assign lcd_ready   = lcd_ready_q;
    assign irq         = done_q & irq_en_q;

endmodule

// File: tb/tb_lt24_reset_sequencer.sv
// Scoreboard bench for lt24_reset_sequencer: expected pin edges and register
// reads are queued by the stimulus and checked by an independent monitor.
module tb_lt24_reset_sequencer;
    import lt24_pkg::*;

    logic clk = 1'b0;
    logic reset_a, reset_b;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    lt24_reset_sequencer_if bus_a ();
    lt24_reset_sequencer_if bus_b ();

    logic lcd_reset_n_a, lcd_ready_a, irq_a;
    logic lcd_reset_n_b, lcd_ready_b, irq_b;

    lt24_reset_sequencer #(
        .CNT_W (24), .LOW_DEFAULT (5), .WAIT_DEFAULT (8), .AUTO_START (1)
    ) dut_a (
        .clk (clk), .reset (reset_a), .bus (bus_a),
        .lcd_reset_n (lcd_reset_n_a), .lcd_ready (lcd_ready_a), .irq (irq_a)
    );

    lt24_reset_sequencer #(
        .CNT_W (24), .LOW_DEFAULT (5), .WAIT_DEFAULT (8), .AUTO_START (0)
    ) dut_b (
        .clk (clk), .reset (reset_b), .bus (bus_b),
        .lcd_reset_n (lcd_reset_n_b), .lcd_ready (lcd_ready_b), .irq (irq_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // pin 0 = lcd_reset_n, pin 1 = lcd_ready; 'at' is the cycle count after the edge
    typedef struct packed {logic d; logic pin; logic val; int at;} edge_t;
    typedef struct packed {logic d; logic [34:0] exp;} rd_t;

    edge_t edge_q[$];
    rd_t   rd_q[$];
    string rd_name_q[$];

    logic [1:0]  prev_rstn, prev_rdy, cur_rstn, cur_rdy;
    logic [34:0] got;
    bit          started = 0;

    task automatic check_edge(input int d, input int pin, input logic v);
        int idx;
        string nm;
        idx = -1;
        nm = (pin == 0) ? "lcd_reset_n" : "lcd_ready";
        vectors++;
        foreach (edge_q[i]) begin
            if (idx < 0 && edge_q[i].d == d[0] && edge_q[i].pin == pin[0]) idx = i;
        end
        if (idx < 0) begin
            miscompares++;
            $display("FAIL edge dut%0d %s: changed to %0b at cycle %0d, required no change",
                     d, nm, v, cyc);
        end else begin
            if (edge_q[idx].val !== v || edge_q[idx].at != cyc) begin
                miscompares++;
                $display("FAIL edge dut%0d %s: got %0b at cycle %0d, required %0b at cycle %0d",
                         d, nm, v, cyc, edge_q[idx].val, edge_q[idx].at);
            end
            edge_q.delete(idx);
        end
    endtask

    // Monitor: pin edges and presented reads, sampled on the falling edge.
    always @(negedge clk) begin
        cur_rstn = {lcd_reset_n_b, lcd_reset_n_a};
        cur_rdy  = {lcd_ready_b, lcd_ready_a};
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                if (cur_rstn[d] !== prev_rstn[d]) check_edge(d, 0, cur_rstn[d]);
                if (cur_rdy[d] !== prev_rdy[d]) check_edge(d, 1, cur_rdy[d]);
            end
        end
        prev_rstn = cur_rstn;
        prev_rdy  = cur_rdy;
        started   = 1;
        if (rd_q.size() != 0) begin
            if (rd_q[0].d ? (bus_b.chipselect && bus_b.write_n)
                          : (bus_a.chipselect && bus_a.write_n)) begin
                got = rd_q[0].d ? {bus_b.readdata, irq_b, lcd_reset_n_b, lcd_ready_b}
                                : {bus_a.readdata, irq_a, lcd_reset_n_a, lcd_ready_a};
                vectors++;
                if (got !== rd_q[0].exp) begin
                    miscompares++;
                    $display("FAIL %s: {readdata,irq,rst_n,ready} got %h_%b required %h_%b",
                             rd_name_q[0], got[34:3], got[2:0], rd_q[0].exp[34:3],
                             rd_q[0].exp[2:0]);
                end
                void'(rd_q.pop_front());
                void'(rd_name_q.pop_front());
            end
        end
    end

    task automatic drive(input int d, input logic cs, input logic wn, input logic [1:0] a,
                         input logic [31:0] v);
        if (d == 0) begin
            bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.address = a; bus_a.writedata = v;
        end else begin
            bus_b.chipselect = cs; bus_b.write_n = wn; bus_b.address = a; bus_b.writedata = v;
        end
    endtask

    // Returns the cycle count of the edge that sampled the write.
    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v, output int w);
        drive(d, 1'b1, 1'b0, a, v);
        @(posedge clk);
        #1;
        w = cyc;
        drive(d, 1'b0, 1'b1, 2'd0, 32'd0);
    endtask

    task automatic rd(input int d, input logic [1:0] a, input logic [31:0] er, input logic ei,
                      input logic ern, input logic erd, input string nm);
        rd_t e;
        e.d   = d[0];
        e.exp = {er, ei, ern, erd};
        rd_q.push_back(e);
        rd_name_q.push_back(nm);
        drive(d, 1'b1, 1'b1, a, 32'd0);
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b1, 2'd0, 32'd0);
    endtask

    task automatic expect_edge(input int d, input int pin, input logic v, input int at);
        edge_t e;
        e.d = d[0]; e.pin = pin[0]; e.val = v; e.at = at;
        edge_q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, c0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        drive(0, 1'b0, 1'b1, 2'd0, 32'd0);
        drive(1, 1'b0, 1'b1, 2'd0, 32'd0);
        @(posedge clk);
        #1;

        // Reset state
        rd(0, ADDR_LOW, 32'd5, 0, 0, 0, "A reset LOW_CYC");
        rd(0, ADDR_WAIT, 32'd8, 0, 0, 0, "A reset WAIT_CYC");
        rd(0, ADDR_STATUS, 32'd0, 0, 0, 0, "A reset STATUS");
        rd(1, ADDR_CTRL, 32'd0, 0, 0, 0, "B reset CTRL");

        // 1: auto start, 5 low cycles then 8 wait cycles
        reset_a = 1'b0;
        reset_b = 1'b0;
        c0 = cyc;
        expect_edge(0, 0, 1'b1, c0 + 6);
        expect_edge(0, 1, 1'b1, c0 + 14);
        rd(0, ADDR_STATUS, 32'h0, 0, 0, 0, "A idle before auto start");
        rd(0, ADDR_STATUS, 32'h1, 0, 0, 0, "A auto start ASSERT");
        wait_until(c0 + 14);
        rd(0, ADDR_STATUS, 32'h0B, 0, 1, 1, "A ready STATUS");

        // 2: manual start with programmed 3/4 timing
        rd(1, ADDR_STATUS, 32'h0, 0, 0, 0, "B idle without START");
        wr(1, ADDR_LOW, 32'd3, w);
        wr(1, ADDR_WAIT, 32'd4, w);
        rd(1, ADDR_LOW, 32'd3, 0, 0, 0, "B LOW_CYC readback");
        rd(1, ADDR_WAIT, 32'd4, 0, 0, 0, "B WAIT_CYC readback");
        wr(1, ADDR_CTRL, 32'd1, w);
        expect_edge(1, 0, 1'b1, w + 3);
        expect_edge(1, 1, 1'b1, w + 7);
        rd(1, ADDR_STATUS, 32'h1, 0, 0, 0, "B ASSERT after START");
        wait_until(w + 7);
        rd(1, ADDR_STATUS, 32'h0B, 0, 1, 1, "B ready STATUS");
        rd(1, ADDR_CTRL, 32'h0, 0, 1, 1, "B CTRL START self-clears");

        // 3: restart two cycles into WAIT
        wr(1, ADDR_STATUS, 32'h08, w);
        wr(1, ADDR_CTRL, 32'd1, w);
        expect_edge(1, 0, 1'b0, w);
        expect_edge(1, 1, 1'b0, w);
        expect_edge(1, 0, 1'b1, w + 3);
        wait_until(w + 4);
        wr(1, ADDR_CTRL, 32'd1, w);
        expect_edge(1, 0, 1'b0, w);
        expect_edge(1, 0, 1'b1, w + 3);
        expect_edge(1, 1, 1'b1, w + 7);
        rd(1, ADDR_STATUS, 32'h1, 0, 0, 0, "B restart, done still clear");
        wait_until(w + 7);
        rd(1, ADDR_STATUS, 32'h0B, 0, 1, 1, "B restart ready");

        // 4: HOLD from READY, START ignored while held, release runs full sequence
        wr(1, ADDR_CTRL, 32'd2, w);
        expect_edge(1, 0, 1'b0, w);
        expect_edge(1, 1, 1'b0, w);
        rd(1, ADDR_STATUS, 32'h0C, 0, 0, 0, "B HOLD entered");
        wait_until(w + 100);
        rd(1, ADDR_STATUS, 32'h0C, 0, 0, 0, "B HOLD after 100 cycles");
        rd(1, ADDR_CTRL, 32'h2, 0, 0, 0, "B CTRL HOLD readback");
        wr(1, ADDR_CTRL, 32'd3, w);
        rd(1, ADDR_STATUS, 32'h0C, 0, 0, 0, "B HOLD beats START");
        wr(1, ADDR_CTRL, 32'd0, w);
        expect_edge(1, 0, 1'b1, w + 3);
        expect_edge(1, 1, 1'b1, w + 7);
        rd(1, ADDR_STATUS, 32'h09, 0, 0, 0, "B HOLD release ASSERT");
        wait_until(w + 7);
        rd(1, ADDR_STATUS, 32'h0B, 0, 1, 1, "B HOLD release ready");

        // 5: zero timing registers behave as one cycle each
        wr(1, ADDR_LOW, 32'd0, w);
        wr(1, ADDR_WAIT, 32'd0, w);
        wr(1, ADDR_CTRL, 32'd1, w);
        expect_edge(1, 0, 1'b0, w);
        expect_edge(1, 1, 1'b0, w);
        expect_edge(1, 0, 1'b1, w + 1);
        expect_edge(1, 1, 1'b1, w + 2);
        rd(1, ADDR_STATUS, 32'h09, 0, 0, 0, "B zero timing ASSERT");
        wait_until(w + 2);
        rd(1, ADDR_STATUS, 32'h0B, 0, 1, 1, "B zero timing ready");

        // 6: interrupt enable, clear, set-wins, async reset
        wr(1, ADDR_STATUS, 32'h08, w);
        rd(1, ADDR_STATUS, 32'h03, 0, 1, 1, "B done cleared");
        wr(1, ADDR_STATUS, 32'h10, w);
        rd(1, ADDR_STATUS, 32'h13, 0, 1, 1, "B irq_en set");
        wr(1, ADDR_CTRL, 32'd1, w);
        expect_edge(1, 0, 1'b0, w);
        expect_edge(1, 1, 1'b0, w);
        expect_edge(1, 0, 1'b1, w + 1);
        expect_edge(1, 1, 1'b1, w + 2);
        wait_until(w + 2);
        rd(1, ADDR_STATUS, 32'h1B, 1, 1, 1, "B irq raised");
        wr(1, ADDR_STATUS, 32'h18, w);
        rd(1, ADDR_STATUS, 32'h13, 0, 1, 1, "B irq cleared");
        wr(1, ADDR_CTRL, 32'd1, w);
        expect_edge(1, 0, 1'b0, w);
        expect_edge(1, 1, 1'b0, w);
        expect_edge(1, 0, 1'b1, w + 1);
        expect_edge(1, 1, 1'b1, w + 2);
        wait_until(w + 1);
        wr(1, ADDR_STATUS, 32'h18, w);
        rd(1, ADDR_STATUS, 32'h1B, 1, 1, 1, "B set wins over clear");
        wr(1, ADDR_STATUS, 32'h18, w);
        rd(1, ADDR_STATUS, 32'h13, 0, 1, 1, "B irq cleared again");

        wr(1, ADDR_LOW, 32'd3, w);
        wr(1, ADDR_WAIT, 32'd4, w);
        wr(1, ADDR_CTRL, 32'd1, w);
        expect_edge(1, 0, 1'b0, w);
        expect_edge(1, 1, 1'b0, w);
        reset_b = 1'b1;
        rd(1, ADDR_STATUS, 32'h0, 0, 0, 0, "B reset during ASSERT");
        rd(1, ADDR_LOW, 32'd5, 0, 0, 0, "B reset restores LOW_CYC");
        reset_b = 1'b0;

        wr(1, ADDR_CTRL, 32'd1, w);
        expect_edge(1, 0, 1'b1, w + 5);
        wait_until(w + 6);
        expect_edge(1, 0, 1'b0, cyc);
        reset_b = 1'b1;
        rd(1, ADDR_STATUS, 32'h0, 0, 0, 0, "B reset during WAIT");
        reset_b = 1'b0;
        wait_until(cyc + 3);
        rd(1, ADDR_STATUS, 32'h0, 0, 0, 0, "B idle after reset");

        wait_until(cyc + 3);
        vectors++;
        if (edge_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending edges: got %0d never seen, required 0 (first dut%0d pin%0d at %0d)",
                     edge_q.size(), edge_q[0].d, edge_q[0].pin, edge_q[0].at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
